ps2_keyboard_rx: RTL
====================

# ps2_keyboard_rx

PS/2 keyboard receiver that deserialises device-to-host frames from the keyboard's PS/2 clock/data lines and decodes Set-2 make/break sequences into single-cycle key events. It is the producer feeding the tone generator's `key_code` / `key_valid` / `key_released` inputs, running in the 100 MHz system clock domain.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; documents the cycle math below.
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYCLES`, 200_000: idle cycles (2 ms) mid-frame before the frame is abandoned.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pin, asynchronous.
- `key_code`  out  8  scan code of the last event; held until the next event.
- `key_valid`  out  1  one-cycle pulse: make (press or typematic repeat) of `key_code`.
- `key_released`  out  1  one-cycle pulse: break of `key_code`.
- `key_extended`  out  1  qualifies `key_code`; high if the event was E0-prefixed; held with `key_code`.
- `frame_err`  out  1  one-cycle pulse on a discarded frame.

## Operation
- Line front end: `ps2_clk` and `ps2_data` each pass through 2-flop synchronisers. `ps2_clk` then goes through a `FILTER_LEN` stability filter. A filtered 1→0 transition produces a one-cycle `fall` strobe, and synchronised `ps2_data` is sampled on that cycle.
- Frame FSM: IDLE → SHIFT → CHECK → IDLE.
  - IDLE: on `fall`, data=0 (start bit) → SHIFT with bit count 0. Data=1 is a glitch: stay in IDLE, no error.
  - SHIFT: on each `fall`, shift in bits 0..7 LSB first, then parity, then stop. After the stop bit → CHECK.
  - CHECK, one cycle: the frame is good iff stop=1 and (with the macro) the 9 bits of data+parity have odd parity. Good frame → byte to decoder. Bad frame → `frame_err` pulse, prefix flags cleared. Then → IDLE.
  - Timeout: a 32-bit counter clears on every `fall` and runs in SHIFT and CHECK. When it reaches `TIMEOUT_CYCLES` → IDLE, pulse `frame_err`, clear prefix flags.
- Decoder flags are `ext_pend` and `brk_pend`.
  - Byte 0xE0 sets `ext_pend`. Byte 0xF0 sets `brk_pend`. Neither byte emits an event.
  - Any other byte: `key_code`=byte, `key_extended`=`ext_pend`. Pulse `key_released` if `brk_pend`, else pulse `key_valid`. Then clear both flags.
  - The sequence E0 F0 xx yields a break with `key_extended`=1.
- `key_valid` and `key_released` are never high in the same cycle. `frame_err` is never coincident with either.
- Reset values: `key_code`=8'h00, `key_valid`=0, `key_released`=0, `key_extended`=0, `frame_err`=0, FSM=IDLE, flags clear, filter output=1.

## Timing
- `fall` asserts 2 (sync) + `FILTER_LEN` cycles after the raw pin edge, with a ±1 cycle tolerance.
- Event or `frame_err` outputs are registered and assert exactly 2 cycles after the `fall` of the stop bit: 1 cycle in CHECK, 1 cycle in the output register. Pulses are exactly one cycle wide.
- No back-pressure. Events are single-shot and the consumer must sample every cycle. The next frame cannot complete within less than ~600 µs, so events cannot overlap.
- `rst_n` asserted mid-frame clears everything immediately. The first `fall` after release must be a start bit; a partial frame in flight is dropped by the start-bit rule or by timeout.
- The counter saturates at `TIMEOUT_CYCLES`; it does not wrap. The counter is idle in IDLE.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a parity mismatch discards the frame and pulses `frame_err`.
- Not defined: the parity bit is shifted and ignored. Only stop-bit and timeout errors raise `frame_err`.

## Structure
- Shared package `ps2_pkg`: `PS2_PREFIX_EXT`=8'hE0, `PS2_PREFIX_BRK`=8'hF0, frame FSM state encoding, `PS2_FRAME_BITS`=11.
- One sub-module, `ps2_line_filter`: synchroniser, stability filter and `fall` strobe for one line; instantiated for `ps2_clk`, while `ps2_data` uses only its synchroniser path. The frame FSM, timeout and decoder stay in the top module.

## Test plan
The bench drives the PS/2 lines at 12.5 kHz (80 µs bit period, data changed mid-high).
- Frame 0x1A, parity 0 → one `key_valid` pulse, `key_code`=8'h1A, `key_extended`=0, 2 cycles after the filtered stop-bit fall.
- Frames F0, 1A → no event after F0; then `key_released` pulse with `key_code`=8'h1A.
- Frames E0, F0, 75 → `key_released`, `key_code`=8'h75, `key_extended`=1. A following frame 22 → `key_valid` with `key_extended`=0.
- Frame 0x22 with a wrong parity bit → with the macro: `frame_err` pulse and no key event; without the macro: `key_valid` with code 8'h22.
- Stop bit driven 0, or the clock stopped after 5 bits for more than 2 ms → `frame_err` pulse, FSM back in IDLE. A following good frame 0x21 → `key_valid`, 8'h21.
- A 3-cycle glitch low on `ps2_clk`, and separately `rst_n` pulsed low mid-frame → no `fall` and no outputs; all outputs 0 during and after reset until a complete new frame.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - Set-2 prefix bytes (extended / break)
//   - frame length and idle line level
//   - frame FSM state encoding
//   - odd-parity helper over data+parity bits
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  // Both PS/2 lines idle high (open collector with pull-ups).
  localparam logic       PS2_LINE_IDLE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } frame_state_e;

  // True when the 8 data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Conditions one raw PS/2 line into the system clock domain.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   line_raw  in   raw pin level, asynchronous
//   line_sync out  line after a 2-flop synchroniser
//   line_filt out  synchronised line after a FILTER_LEN stability filter
//   fall      out  one-cycle strobe on a filtered 1->0 transition
// The filtered level only changes after FILTER_LEN consecutive synchronised
// samples disagree with it, so short glitches never produce a strobe.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_raw,
  output logic line_sync,
  output logic line_filt,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       sync_r;
  logic             filt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fall_r;

  logic [CNT_W-1:0] cnt_nxt_s;
  logic             filt_nxt_s;
  logic             fall_nxt_s;

  // Stability counter: counts samples that disagree with the filtered level.
  always_comb begin
    cnt_nxt_s  = CNT_ZERO;
    filt_nxt_s = filt_r;
    fall_nxt_s = 1'b0;
    if (sync_r[1] != filt_r) begin
      if (cnt_r >= CNT_LAST) begin
        filt_nxt_s = sync_r[1];
        cnt_nxt_s  = CNT_ZERO;
        // Disagreeing with a high filtered level means the line went low.
        fall_nxt_s = filt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = CNT_ZERO;
    end
  end

  // Synchroniser, filter state and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {2{PS2_LINE_IDLE}};
      filt_r <= PS2_LINE_IDLE;
      cnt_r  <= CNT_ZERO;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], line_raw};
      filt_r <= filt_nxt_s;
      cnt_r  <= cnt_nxt_s;
      fall_r <= fall_nxt_s;
    end
  end

  assign line_sync = sync_r[1];
  assign line_filt = filt_r;
  assign fall      = fall_r;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// PS/2 keyboard receiver: deserialises device-to-host frames and decodes
// Set-2 make/break sequences (with E0 extended prefix) into one-cycle events.
//   clk          in   system clock (CLK_HZ), rising edge
//   rst_n        in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock pin
//   ps2_data     in   raw PS/2 data pin
//   key_code     out  scan code of the last event, held
//   key_valid    out  one-cycle make pulse
//   key_released out  one-cycle break pulse
//   key_extended out  event was E0-prefixed, held with key_code
//   frame_err    out  one-cycle pulse on a discarded frame
// Optional feature: define PS2_PARITY_CHECK_EN to discard frames whose
// data+parity bits do not have odd parity; otherwise parity is ignored.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_released,
  output logic       key_extended,
  output logic       frame_err
);

  // A zero timeout falls back to 2 ms worth of system clocks.
  localparam logic [31:0] TMO_LIMIT = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES)
                                                           : 32'(CLK_HZ / 500);
  // Bits shifted after the start bit: 8 data, parity, stop (index 0..9).
  localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 2);

  // Line front end
  logic clk_fall_s;
  logic data_sync_s;
  logic clk_sync_unused_s;
  logic clk_filt_unused_s;
  logic data_filt_unused_s;
  logic data_fall_unused_s;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_raw  (ps2_clk),
    .line_sync (clk_sync_unused_s),
    .line_filt (clk_filt_unused_s),
    .fall      (clk_fall_s)
  );

  // Data is only sampled on clean clock falls, so its synchroniser suffices.
  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_data_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_raw  (ps2_data),
    .line_sync (data_sync_s),
    .line_filt (data_filt_unused_s),
    .fall      (data_fall_unused_s)
  );

  // Frame FSM, timeout and decoder state
  frame_state_e state_r,    state_nxt_s;
  logic [3:0]   bit_cnt_r,  bit_cnt_nxt_s;
  logic [9:0]   shift_r,    shift_nxt_s;
  logic [31:0]  tmo_cnt_r,  tmo_cnt_nxt_s;
  logic         ext_pend_r, ext_pend_nxt_s;
  logic         brk_pend_r, brk_pend_nxt_s;

  // Registered outputs
  logic [7:0]   key_code_r,     key_code_nxt_s;
  logic         key_valid_r,    key_valid_nxt_s;
  logic         key_released_r, key_released_nxt_s;
  logic         key_extended_r, key_extended_nxt_s;
  logic         frame_err_r,    frame_err_nxt_s;

  logic         frame_good_s;
  logic         timeout_s;
  logic [7:0]   rx_byte_s;

  assign rx_byte_s = shift_r[7:0];
  assign timeout_s = (tmo_cnt_r >= TMO_LIMIT);

  // Frame acceptance: stop bit high, plus odd parity when checking is built in.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_good_s = shift_r[9] & odd_parity_ok(shift_r[8:0]);
`else
    frame_good_s = shift_r[9];
`endif
  end

  // Timeout counter: cleared in IDLE and on every fall, saturates at the limit.
  always_comb begin
    tmo_cnt_nxt_s = tmo_cnt_r;
    if (state_r == IDLE) begin
      tmo_cnt_nxt_s = 32'd0;
    end else if (clk_fall_s) begin
      tmo_cnt_nxt_s = 32'd0;
    end else if (tmo_cnt_r < TMO_LIMIT) begin
      tmo_cnt_nxt_s = tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_r;
    end
  end

  // Frame FSM next state, shifter, prefix decoder and output pulses.
  always_comb begin
    state_nxt_s        = state_r;
    bit_cnt_nxt_s      = bit_cnt_r;
    shift_nxt_s        = shift_r;
    ext_pend_nxt_s     = ext_pend_r;
    brk_pend_nxt_s     = brk_pend_r;
    key_code_nxt_s     = key_code_r;
    key_extended_nxt_s = key_extended_r;
    key_valid_nxt_s    = 1'b0;
    key_released_nxt_s = 1'b0;
    frame_err_nxt_s    = 1'b0;

    case (state_r)
      IDLE: begin
        // A fall with data high is a glitch, not a start bit.
        if (clk_fall_s && !data_sync_s) begin
          state_nxt_s   = SHIFT;
          bit_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SHIFT: begin
        if (clk_fall_s) begin
          shift_nxt_s = {data_sync_s, shift_r[9:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = CHECK;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          end
        end else if (timeout_s) begin
          state_nxt_s     = IDLE;
          frame_err_nxt_s = 1'b1;
          ext_pend_nxt_s  = 1'b0;
          brk_pend_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = SHIFT;
        end
      end

      CHECK: begin
        state_nxt_s = IDLE;
        if (!frame_good_s) begin
          frame_err_nxt_s = 1'b1;
          ext_pend_nxt_s  = 1'b0;
          brk_pend_nxt_s  = 1'b0;
        end else if (rx_byte_s == PS2_PREFIX_EXT) begin
          ext_pend_nxt_s = 1'b1;
        end else if (rx_byte_s == PS2_PREFIX_BRK) begin
          brk_pend_nxt_s = 1'b1;
        end else begin
          key_code_nxt_s     = rx_byte_s;
          key_extended_nxt_s = ext_pend_r;
          if (brk_pend_r) begin
            key_released_nxt_s = 1'b1;
          end else begin
            key_valid_nxt_s = 1'b1;
          end
          ext_pend_nxt_s = 1'b0;
          brk_pend_nxt_s = 1'b0;
        end
      end

      default: begin
        state_nxt_s    = IDLE;
        ext_pend_nxt_s = 1'b0;
        brk_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      bit_cnt_r      <= 4'd0;
      shift_r        <= 10'd0;
      tmo_cnt_r      <= 32'd0;
      ext_pend_r     <= 1'b0;
      brk_pend_r     <= 1'b0;
      key_code_r     <= 8'h00;
      key_valid_r    <= 1'b0;
      key_released_r <= 1'b0;
      key_extended_r <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      bit_cnt_r      <= bit_cnt_nxt_s;
      shift_r        <= shift_nxt_s;
      tmo_cnt_r      <= tmo_cnt_nxt_s;
      ext_pend_r     <= ext_pend_nxt_s;
      brk_pend_r     <= brk_pend_nxt_s;
      key_code_r     <= key_code_nxt_s;
      key_valid_r    <= key_valid_nxt_s;
      key_released_r <= key_released_nxt_s;
      key_extended_r <= key_extended_nxt_s;
      frame_err_r    <= frame_err_nxt_s;
    end
  end

  assign key_code     = key_code_r;
  assign key_valid    = key_valid_r;
  assign key_released = key_released_r;
  assign key_extended = key_extended_r;
  assign frame_err    = frame_err_r;

endmodule
